// File: rtl/tick_scheduler.sv
// tick_scheduler: a shared prescaler producing a base tick every DIV clocks,
// plus four independently configurable channels that pulse every P base ticks.
// Channels are written through a valid/ready port that is closed only during
// base-tick cycles, so a configuration write never collides with a count step.
module tick_scheduler #(
    parameter int DIV = 100000,
    parameter int PW  = 16
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          run,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_chan,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_en,
    output logic          base_tick,
    output logic [3:0]    ch_tick,
    output logic [3:0]    ch_active
);

    localparam int              PRW        = $clog2(DIV);
    localparam logic [PRW-1:0]  PRESC_LOAD = PRW'(DIV - 1);

    logic [PRW-1:0] r_presc;
    logic           w_base_tick;
    logic           w_xfer;
    logic [3:0]     w_ch_tick;
    logic [3:0]     w_ch_active;

    // The base tick is the last count of the prescaler while running.
    assign w_base_tick = run && (r_presc == '0);
    assign w_xfer      = cfg_valid && !w_base_tick;

    assign base_tick   = w_base_tick;
    assign cfg_ready   = !w_base_tick;
    assign ch_tick     = w_ch_tick;
    assign ch_active   = w_ch_active;

    // Prescaler: held at its preload while stopped so a restart always
    // produces the first base tick a full DIV cycles later.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_presc <= PRESC_LOAD;
        end else if (!run || (r_presc == '0)) begin
            r_presc <= PRESC_LOAD;
        end else begin
            r_presc <= r_presc - PRW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic [PW-1:0] r_period;
            logic [PW-1:0] r_count;
            logic          r_active;
            logic          r_tick;
            logic          w_sel;
            logic          w_expire;

            assign w_sel    = w_xfer && (cfg_chan == 2'(gi));
            assign w_expire = w_base_tick && r_active && (r_count == '0);

            // Channel state: a write restarts the phase (count starts at P-1 so
            // the P-th base tick expires it); otherwise count down on base ticks.
            // A write and a base tick are mutually exclusive by construction.
            always_ff @(posedge clk_in or negedge reset_in) begin
                if (!reset_in) begin
                    r_period <= '0;
                    r_count  <= '0;
                    r_active <= 1'b0;
                end else if (w_sel) begin
                    r_period <= cfg_period;
                    r_count  <= cfg_period - PW'(1);
                    r_active <= cfg_en && (cfg_period != '0);
                end else if (w_base_tick && r_active) begin
                    if (r_count == '0) begin
                        r_count <= r_period - PW'(1);
                    end else begin
                        r_count <= r_count - PW'(1);
                    end
                end
            end

            // Output pulse, registered so it appears the cycle after the base
            // tick; independent of writes so an already-due pulse is never lost.
            always_ff @(posedge clk_in or negedge reset_in) begin
                if (!reset_in) begin
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= w_expire;
                end
            end

            assign w_ch_tick[gi]   = r_tick;
            assign w_ch_active[gi] = r_active;
        end
    endgenerate

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with DIV=10, PW=16.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_tick_scheduler;

    localparam int DIV = 10;
    localparam int PW  = 16;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          run;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [PW-1:0] cfg_period;
    logic          cfg_en;
    logic          base_tick;
    logic [3:0]    ch_tick;
    logic [3:0]    ch_active;

    int errors = 0;
    int checks = 0;

    tick_scheduler #(.DIV(DIV), .PW(PW)) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .base_tick  (base_tick),
        .ch_tick    (ch_tick),
        .ch_active  (ch_active)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; land 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle configuration write (ready is assumed high; caller ensures it).
    task automatic cfg_write(input logic [1:0] ch, input logic [PW-1:0] p, input logic en);
        cfg_valid  = 1'b1;
        cfg_chan   = ch;
        cfg_period = p;
        cfg_en     = en;
        step();
        cfg_valid  = 1'b0;
        $display("cfg write ch=%0d period=%0d en=%0d -> ch_active=%b", ch, p, en, ch_active);
    endtask

    // Step until base_tick is high (bounded); leaves time in the base-tick cycle.
    task automatic advance_to_base();
        int n;
        n = 0;
        while (base_tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (base_tick !== 1'b1) begin
            errors++;
            $display("FAIL base_wait: base_tick=%b after %0d cycles, required 1", base_tick, n);
        end
    endtask

    task automatic test_reset();
        reset_in   = 1'b0;
        run        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_chan   = 2'd0;
        cfg_period = '0;
        cfg_en     = 1'b0;
        #2;
        repeat (3) step();
        checks++;
        if ({base_tick, cfg_ready, ch_active, ch_tick} !== 10'b01_0000_0000) begin
            errors++;
            $display("FAIL reset_state: base=%b ready=%b active=%b tick=%b, required 0 1 0000 0000",
                     base_tick, cfg_ready, ch_active, ch_tick);
        end
        $display("reset: base=%b ready=%b active=%b tick=%b", base_tick, cfg_ready, ch_active, ch_tick);
    endtask

    task automatic test_base_tick();
        logic exp;
        reset_in = 1'b1;    // first cycle with run=1 is this one
        for (int c = 1; c <= 30; c++) begin
            exp = (c % 10 == 0);
            checks++;
            if (base_tick !== exp || cfg_ready !== !exp) begin
                errors++;
                $display("FAIL base_tick_c%0d: base=%b ready=%b, required base=%b ready=%b",
                         c, base_tick, cfg_ready, exp, !exp);
            end
            if (exp) $display("cycle %0d: base_tick=%b cfg_ready=%b", c, base_tick, cfg_ready);
            step();
        end
    endtask

    task automatic test_single_channel();
        logic [3:0] exp;
        cfg_write(2'd0, 16'd3, 1'b1);
        checks++;
        if (ch_active !== 4'b0001) begin
            errors++;
            $display("FAIL ch0_active: ch_active=%b, required 0001", ch_active);
        end
        for (int k = 1; k <= 9; k++) begin
            advance_to_base();
            checks++;
            if (ch_tick !== 4'b0000) begin
                errors++;
                $display("FAIL ch0_tick_during_base_%0d: ch_tick=%b, required 0000", k, ch_tick);
            end
            step();
            exp = (k % 3 == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if (ch_tick !== exp) begin
                errors++;
                $display("FAIL ch0_tick_after_base_%0d: ch_tick=%b, required %b", k, ch_tick, exp);
            end
            $display("single: base %0d -> ch_tick=%b", k, ch_tick);
        end
    endtask

    task automatic test_multi_channel();
        logic [3:0] exp;
        cfg_write(2'd1, 16'd1, 1'b1);
        cfg_write(2'd2, 16'd2, 1'b1);
        checks++;
        if (ch_active !== 4'b0111) begin
            errors++;
            $display("FAIL multi_active: ch_active=%b, required 0111", ch_active);
        end
        for (int k = 1; k <= 6; k++) begin
            advance_to_base();
            step();
            exp = {1'b0, (k % 2 == 0), 1'b1, (k % 3 == 0)};
            checks++;
            if (ch_tick !== exp) begin
                errors++;
                $display("FAIL multi_tick_%0d: ch_tick=%b, required %b", k, ch_tick, exp);
            end
            $display("multi: base %0d -> ch_tick=%b", k, ch_tick);
        end
    endtask

    task automatic test_back_to_back();
        advance_to_base();
        cfg_valid  = 1'b1;
        cfg_chan   = 2'd3;
        cfg_period = 16'd5;
        cfg_en     = 1'b1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_ready_at_base: cfg_ready=%b, required 0", cfg_ready);
        end
        step();
        checks++;
        if (ch_active !== 4'b0111 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_no_xfer_at_base: ch_active=%b ready=%b, required 0111 1", ch_active, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (ch_active !== 4'b1111) begin
            errors++;
            $display("FAIL hs_xfer_next: ch_active=%b, required 1111", ch_active);
        end
        $display("handshake: held through base, active=%b", ch_active);
        cfg_write(2'd3, 16'd0, 1'b1);
        checks++;
        if (ch_active !== 4'b0111) begin
            errors++;
            $display("FAIL period_zero: ch_active=%b, required 0111", ch_active);
        end
    endtask

    task automatic test_run_pause();
        cfg_write(2'd2, 16'd2, 1'b1);   // ch2 phase restarts: pulse after 2nd tick
        advance_to_base();
        step();
        checks++;
        if (ch_tick[2:1] !== 2'b01) begin
            errors++;
            $display("FAIL pause_pre: ch_tick[2:1]=%b, required 01", ch_tick[2:1]);
        end
        run = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            step();
            checks++;
            if (base_tick !== 1'b0 || ch_tick !== 4'b0000) begin
                errors++;
                $display("FAIL paused_c%0d: base=%b ch_tick=%b, required 0 0000", c, base_tick, ch_tick);
            end
        end
        $display("pause: 25 idle cycles, base=%b ch_tick=%b", base_tick, ch_tick);
        run = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (base_tick !== (c == 10)) begin
                errors++;
                $display("FAIL resume_c%0d: base=%b, required %b", c, base_tick, (c == 10));
            end
            if (c < 10) step();
        end
        step();
        checks++;
        if (ch_tick[2:1] !== 2'b11) begin
            errors++;
            $display("FAIL resume_tick1: ch_tick[2:1]=%b, required 11", ch_tick[2:1]);
        end
        advance_to_base();
        step();
        checks++;
        if (ch_tick[2:1] !== 2'b01) begin
            errors++;
            $display("FAIL resume_tick2: ch_tick[2:1]=%b, required 01", ch_tick[2:1]);
        end
        $display("resume: phases continue, ch_tick=%b", ch_tick);
    endtask

    task automatic test_reset_midflight();
        advance_to_base();
        step();
        checks++;
        if (ch_tick[1] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pending: ch_tick[1]=%b, required 1", ch_tick[1]);
        end
        #3 reset_in = 1'b0;
        #1;
        checks++;
        if ({base_tick, cfg_ready, ch_active, ch_tick} !== 10'b01_0000_0000) begin
            errors++;
            $display("FAIL midreset_async: base=%b ready=%b active=%b tick=%b, required 0 1 0000 0000",
                     base_tick, cfg_ready, ch_active, ch_tick);
        end
        $display("mid reset: active=%b tick=%b", ch_active, ch_tick);
        step();
        checks++;
        if ({base_tick, cfg_ready, ch_active, ch_tick} !== 10'b01_0000_0000) begin
            errors++;
            $display("FAIL midreset_held: base=%b ready=%b active=%b tick=%b, required 0 1 0000 0000",
                     base_tick, cfg_ready, ch_active, ch_tick);
        end
        reset_in = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (base_tick !== (c == 10) || ch_tick !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_c%0d: base=%b ch_tick=%b, required %b 0000",
                         c, base_tick, ch_tick, (c == 10));
            end
            if (c < 10) step();
        end
        $display("post reset: first base_tick 10 cycles after release");
    endtask

    initial begin
        test_reset();
        test_base_tick();
        test_single_channel();
        test_multi_channel();
        test_back_to_back();
        test_run_pause();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
